// File: rtl/ha_array_accumulator.sv
// ha_array_accumulator
//   Consumer end of the ha_array interface produced by the 8x8 unsigned
//   approximate multiplier front-ends. It captures four half-adder row pairs
//   (b, t) in one handshake, reduces them into a 17-bit accumulator over
//   4/ROWS_PER_CYC cycles, and presents a saturated product on a
//   valid/ready output.
//
// Parameters
//   ROWS_PER_CYC  rows folded into the accumulator per ACC cycle (1, 2 or 4)
//   PROD_W        output product width; larger sums saturate to all-ones
//
// Ports
//   clk                         rising-edge clock
//   rst_n                       asynchronous active-low reset
//   in_valid / in_ready         input handshake for one row set
//   ha_array_<r>_b  [6:0]       row r, bit k weighs 2^(k+2) inside the row
//   ha_array_<r>_t  [8:0]       row r, bit k weighs 2^k inside the row
//   out_valid / out_ready       output handshake
//   prod [PROD_W-1:0]           reduced (saturated) product
//   ovf                         the sum exceeded 2^PROD_W-1
module ha_array_accumulator #(
  parameter int ROWS_PER_CYC = 1,
  parameter int PROD_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        ha_array_0_b,
  input  logic [6:0]        ha_array_1_b,
  input  logic [6:0]        ha_array_2_b,
  input  logic [6:0]        ha_array_3_b,
  input  logic [8:0]        ha_array_0_t,
  input  logic [8:0]        ha_array_1_t,
  input  logic [8:0]        ha_array_2_t,
  input  logic [8:0]        ha_array_3_t,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] prod,
  output logic              ovf
);

  localparam int ACC_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  state_t state;
  state_t next_state;

  logic [6:0]       b_q [4];
  logic [8:0]       t_q [4];
  logic [9:0]       row_val [4];
  logic [ACC_W-1:0] weighted [4];
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] add_sum;
  logic [ACC_W-1:0] acc_next;
  logic [2:0]       row_cnt;
  logic [2:0]       row_cnt_next;
  logic             last_step;
  logic [1:0]       idx;

  logic [PROD_W+ACC_W-1:0] sum_ext;
  logic                    sat;
  logic [PROD_W-1:0]       prod_next;

  // Each row collapses to a 10-bit value (t plus b shifted by two), then
  // takes its row weight of 4^r inside the 17-bit accumulator domain.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_val[r]  = {1'b0, t_q[r]} + {1'b0, b_q[r], 2'b00};
      weighted[r] = {7'b0, row_val[r]} << (2 * r);
    end
  end

  // Fold the next ROWS_PER_CYC rows, starting at row_cnt, into this cycle's
  // contribution. The final sum is saturated here so that prod/ovf can be
  // registered on the same edge that adds the last row.
  always_comb begin
    add_sum = '0;
    idx     = '0;
    for (int i = 0; i < ROWS_PER_CYC; i++) begin
      idx     = row_cnt[1:0] + 2'(i);
      add_sum = add_sum + weighted[idx];
    end
    acc_next     = acc + add_sum;
    row_cnt_next = row_cnt + 3'(ROWS_PER_CYC);
    last_step    = (row_cnt_next == 3'd4);
    sum_ext      = {{PROD_W{1'b0}}, acc_next};
    sat          = |(sum_ext >> PROD_W);
    prod_next    = sat ? '1 : sum_ext[PROD_W-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode. Rows that are zero still take their
  // ACC cycles, so latency never depends on the data.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = ACC;
        end
      end
      ACC: begin
        if (last_step) begin
          next_state = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: rows are captured only on the accepting edge, so later changes
  // on the ha_array inputs cannot leak into a reduction in flight. prod/ovf
  // stay untouched in OUT, which keeps them stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      row_cnt <= '0;
      prod    <= '0;
      ovf     <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        b_q[r] <= '0;
        t_q[r] <= '0;
      end
    end else if (state == IDLE) begin
      if (in_valid) begin
        b_q[0]  <= ha_array_0_b;
        b_q[1]  <= ha_array_1_b;
        b_q[2]  <= ha_array_2_b;
        b_q[3]  <= ha_array_3_b;
        t_q[0]  <= ha_array_0_t;
        t_q[1]  <= ha_array_1_t;
        t_q[2]  <= ha_array_2_t;
        t_q[3]  <= ha_array_3_t;
        acc     <= '0;
        row_cnt <= '0;
      end
    end else if (state == ACC) begin
      acc     <= acc_next;
      row_cnt <= row_cnt_next;
      if (last_step) begin
        prod <= prod_next;
        ovf  <= sat;
      end
    end
  end

endmodule
